pwm_ramp_sequencer: RTL and testbench

Wishbone-master sequencer that programs one PWM/timer peripheral over its 16-bit Wishbone slave bus and ramps its duty cycle from a start value to a target value in fixed steps at a programmable interval. The host configures the ramp through a small Wishbone slave port. The block sits between the host interconnect and the PWM slave, offloading soft-start/soft-stop duty ramps from firmware. It raises a level interrupt when the ramp completes or the bus errors out.

---
 rtl/pwm_seq_pkg.sv | 38 +++
 rtl/pwm_seq_wb_master.sv | 68 ++++++
 rtl/pwm_ramp_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared constants and state encoding for the PWM ramp sequencer.
package pwm_seq_pkg;

  // PWM peripheral register byte addresses
  localparam logic [15:0] PwmAdrCtrl = 16'd0;
  localparam logic [15:0] PwmAdrDiv  = 16'd2;
  localparam logic [15:0] PwmAdrPer  = 16'd4;
  localparam logic [15:0] PwmAdrDc   = 16'd6;

  // Host-facing register byte addresses
  localparam logic [15:0] SregSctrl  = 16'd0;
  localparam logic [15:0] SregDiv    = 16'd2;
  localparam logic [15:0] SregPer    = 16'd4;
  localparam logic [15:0] SregDcStrt = 16'd6;
  localparam logic [15:0] SregDcTgt  = 16'd8;
  localparam logic [15:0] SregStep   = 16'd10;
  localparam logic [15:0] SregIntvl  = 16'd12;
  localparam logic [15:0] SregStatus = 16'd14;

  // PWM ctrl values
  localparam logic [15:0] CtrlCntRst = 16'h0080;
  localparam logic [15:0] CtrlStop   = 16'h0000;

  typedef enum logic [3:0] {
    StIdle,
    StWRst,
    StWDiv,
    StWPer,
    StWDc0,
    StWRun,
    StWait,
    StWStep,
    StDone,
    StAbortStop,
    StErr
  } seq_state_e;

endpackage

// File: rtl/pwm_seq_wb_master.sv
// Single-write Wishbone master: holds the bus until ack or timeout, then
// reports a one-cycle done or err pulse while the bus is idle.
module pwm_seq_wb_master #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic        req,
  input  logic [15:0] req_adr,
  input  logic [15:0] req_data,
  output logic        wr_done,
  output logic        wr_err,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic [15:0] m_adr,
  output logic [15:0] m_data,
  input  logic        m_ack
);

  logic        active_q;
  logic [15:0] adr_q;
  logic [15:0] data_q;
  logic [15:0] tmo_cnt_q;

  // Bus ownership, hold-until-ack and timeout; the pulse cycle doubles as the
  // mandatory idle cycle so a still-asserted req is not re-accepted.
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      active_q  <= 1'b0;
      adr_q     <= '0;
      data_q    <= '0;
      tmo_cnt_q <= '0;
      wr_done   <= 1'b0;
      wr_err    <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      if (active_q) begin
        if (m_ack) begin
          active_q <= 1'b0;
          adr_q    <= '0;
          data_q   <= '0;
          wr_done  <= 1'b1;
        end else if (tmo_cnt_q == 16'(ACK_TIMEOUT - 1)) begin
          active_q <= 1'b0;
          adr_q    <= '0;
          data_q   <= '0;
          wr_err   <= 1'b1;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
      end else if (req && !wr_done && !wr_err) begin
        active_q  <= 1'b1;
        adr_q     <= req_adr;
        data_q    <= req_data;
        tmo_cnt_q <= '0;
      end
    end
  end

  assign m_cyc  = active_q;
  assign m_stb  = active_q;
  assign m_we   = active_q;
  assign m_adr  = adr_q;
  assign m_data = data_q;

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Host-configured duty-cycle ramp engine driving a PWM peripheral over Wishbone.
module pwm_ramp_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter logic [7:0]  PWM_RUN_CTRL = 8'h16
) (
  input  logic        i_wb_clk,
  input  logic        i_wb_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [15:0] i_wb_adr,
  input  logic [15:0] i_wb_data,
  output logic [15:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_m_cyc,
  output logic        o_m_stb,
  output logic        o_m_we,
  output logic [15:0] o_m_adr,
  output logic [15:0] o_m_data,
  input  logic        i_m_ack,
  output logic        o_irq
);

  seq_state_e  state_q;
  logic [15:0] div_q, per_q, dcs_q, dct_q, step_q, ivl_q;
  logic [15:0] div_sh_q, per_sh_q, dcs_sh_q, dct_sh_q, step_sh_q, ivl_sh_q;
  logic [15:0] cur_dc_q, wait_cnt_q;
  logic        done_q, err_q, abort_pend_q;

  logic        slv_wr, sctrl_wr, start_req, irq_clr, abort_req, busy, ramp_up;
  logic [16:0] sum, dif;
  logic [15:0] next_dc, ivl_eff;
  logic        req, mst_done, mst_err;
  logic [15:0] req_adr, req_data;

  assign slv_wr    = i_wb_cyc & i_wb_stb & i_wb_we;
  assign sctrl_wr  = slv_wr && (i_wb_adr == SregSctrl);
  // Abort outranks start when both are set in one write
  assign start_req = sctrl_wr & i_wb_data[0] & ~i_wb_data[2];
  assign irq_clr   = sctrl_wr & i_wb_data[1];
  assign abort_req = sctrl_wr & i_wb_data[2];
  assign busy      = !(state_q inside {StIdle, StDone, StErr});
  assign o_wb_ack  = i_wb_stb;
  assign o_irq     = done_q | err_q;

  // Next duty value: 17-bit step, clamped to target on overshoot or wrap
  always_comb begin
    ramp_up = (dct_sh_q >= dcs_sh_q);
    sum     = {1'b0, cur_dc_q} + {1'b0, step_sh_q};
    dif     = {1'b0, cur_dc_q} - {1'b0, step_sh_q};
    ivl_eff = (ivl_sh_q == 16'd0) ? 16'd1 : ivl_sh_q;
    if (step_sh_q == 16'd0) begin
      next_dc = dct_sh_q;
    end else if (ramp_up) begin
      next_dc = (sum > {1'b0, dct_sh_q}) ? dct_sh_q : sum[15:0];
    end else begin
      next_dc = (dif[16] || (dif[15:0] < dct_sh_q)) ? dct_sh_q : dif[15:0];
    end
  end

  // Write request presented to the master engine for each bus-writing state
  always_comb begin
    req      = 1'b1;
    req_adr  = PwmAdrCtrl;
    req_data = CtrlStop;
    unique case (state_q)
      StWRst:      req_data = CtrlCntRst;
      StWDiv:      begin req_adr = PwmAdrDiv; req_data = div_sh_q; end
      StWPer:      begin req_adr = PwmAdrPer; req_data = per_sh_q; end
      StWDc0:      begin req_adr = PwmAdrDc;  req_data = dcs_sh_q; end
      StWRun:      req_data = {8'h00, PWM_RUN_CTRL};
      StWStep:     begin req_adr = PwmAdrDc;  req_data = next_dc; end
      StAbortStop: req_data = CtrlStop;
      default:     req = 1'b0;
    endcase
  end

  // Host register readback, combinational on address
  always_comb begin
    case (i_wb_adr)
      SregDiv:    o_wb_data = div_q;
      SregPer:    o_wb_data = per_q;
      SregDcStrt: o_wb_data = dcs_q;
      SregDcTgt:  o_wb_data = dct_q;
      SregStep:   o_wb_data = step_q;
      SregIntvl:  o_wb_data = ivl_q;
      SregStatus: o_wb_data = {cur_dc_q[12:0], err_q, done_q, busy};
      default:    o_wb_data = '0;
    endcase
  end

  // Host-writable configuration registers
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      {div_q, per_q, dcs_q, dct_q, step_q, ivl_q} <= '0;
    end else if (slv_wr) begin
      case (i_wb_adr)
        SregDiv:    div_q  <= i_wb_data;
        SregPer:    per_q  <= i_wb_data;
        SregDcStrt: dcs_q  <= i_wb_data;
        SregDcTgt:  dct_q  <= i_wb_data;
        SregStep:   step_q <= i_wb_data;
        SregIntvl:  ivl_q  <= i_wb_data;
        default:    ;
      endcase
    end
  end

  // Ramp sequencing FSM; status set events are placed after irq clear so set wins
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state_q      <= StIdle;
      {div_sh_q, per_sh_q, dcs_sh_q, dct_sh_q, step_sh_q, ivl_sh_q} <= '0;
      cur_dc_q     <= '0;
      wait_cnt_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      if (abort_req && busy) abort_pend_q <= 1'b1;
      if (irq_clr) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      unique case (state_q)
        StIdle, StDone, StErr: begin
          if (start_req) begin
            {div_sh_q, per_sh_q, dcs_sh_q} <= {div_q, per_q, dcs_q};
            {dct_sh_q, step_sh_q, ivl_sh_q} <= {dct_q, step_q, ivl_q};
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            abort_pend_q <= 1'b0;
            state_q      <= StWRst;
          end else if (irq_clr) begin
            state_q <= StIdle;
          end
        end
        StWRst, StWDiv, StWPer, StWDc0, StWRun, StWStep: begin
          if (mst_err) begin
            err_q        <= 1'b1;
            abort_pend_q <= 1'b0;
            state_q      <= StErr;
          end else if (mst_done) begin
            if (state_q == StWDc0)  cur_dc_q <= dcs_sh_q;
            if (state_q == StWStep) cur_dc_q <= next_dc;
            wait_cnt_q <= '0;
            if (abort_pend_q) begin
              state_q <= StAbortStop;
            end else begin
              case (state_q)
                StWRst: state_q <= StWDiv;
                StWDiv: state_q <= StWPer;
                StWPer: state_q <= StWDc0;
                StWDc0: state_q <= StWRun;
                StWRun: begin
                  if (cur_dc_q == dct_sh_q) begin
                    done_q  <= 1'b1;
                    state_q <= StDone;
                  end else begin
                    state_q <= StWait;
                  end
                end
                default: begin
                  if (next_dc == dct_sh_q) begin
                    done_q  <= 1'b1;
                    state_q <= StDone;
                  end else begin
                    state_q <= StWait;
                  end
                end
              endcase
            end
          end
        end
        StWait: begin
          if (abort_pend_q) begin
            state_q <= StAbortStop;
          end else if (wait_cnt_q == ivl_eff - 16'd1) begin
            state_q <= StWStep;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        StAbortStop: begin
          if (mst_err) begin
            err_q        <= 1'b1;
            abort_pend_q <= 1'b0;
            state_q      <= StErr;
          end else if (mst_done) begin
            abort_pend_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  pwm_seq_wb_master #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_master (
    .i_wb_clk(i_wb_clk),
    .i_wb_rst(i_wb_rst),
    .req     (req),
    .req_adr (req_adr),
    .req_data(req_data),
    .wr_done (mst_done),
    .wr_err  (mst_err),
    .m_cyc   (o_m_cyc),
    .m_stb   (o_m_stb),
    .m_we    (o_m_we),
    .m_adr   (o_m_adr),
    .m_data  (o_m_data),
    .m_ack   (i_m_ack)
  );

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench: expected PWM write stream from a ramp model, checked by a bus monitor.
module tb_pwm_ramp_sequencer;

  localparam int AckTimeout = 16;

  logic        i_wb_clk = 1'b0;
  logic        i_wb_rst = 1'b1;
  logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
  logic [15:0] i_wb_adr = '0, i_wb_data = '0;
  logic [15:0] o_wb_data;
  logic        o_wb_ack, o_m_cyc, o_m_stb, o_m_we, o_irq;
  logic [15:0] o_m_adr, o_m_data;
  logic        i_m_ack = 1'b0;

  pwm_ramp_sequencer #(
    .ACK_TIMEOUT (16),
    .PWM_RUN_CTRL(8'h16)
  ) dut (
    .i_wb_clk (i_wb_clk),
    .i_wb_rst (i_wb_rst),
    .i_wb_cyc (i_wb_cyc),
    .i_wb_stb (i_wb_stb),
    .i_wb_we  (i_wb_we),
    .i_wb_adr (i_wb_adr),
    .i_wb_data(i_wb_data),
    .o_wb_data(o_wb_data),
    .o_wb_ack (o_wb_ack),
    .o_m_cyc  (o_m_cyc),
    .o_m_stb  (o_m_stb),
    .o_m_we   (o_m_we),
    .o_m_adr  (o_m_adr),
    .o_m_data (o_m_data),
    .i_m_ack  (i_m_ack),
    .o_irq    (o_irq)
  );

  always #5 i_wb_clk = ~i_wb_clk;

  int n_checks = 0, n_err = 0;
  int cyc_n = 0;
  logic [31:0] exp_q[$];
  int wr_count = 0, tmo_count = 0;
  bit noack_en = 1'b0;
  logic [15:0] noack_adr = '0;
  int cur_ivl = 1;

  always @(posedge i_wb_clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Bus monitor and PWM-side responder: compares each write with the expected stream
  int hi_cnt = 0, ack_at = 0, prev_dc_cyc = -1;
  bit was_stb = 1'b0, acked = 1'b0;
  logic [15:0] cap_adr, cap_dat;
  logic [31:0] e;
  always @(negedge i_wb_clk) begin
    if (i_wb_rst) begin
      was_stb = 1'b0;
      i_m_ack = 1'b0;
    end else begin
      if (o_m_stb) begin
        if (!was_stb) begin
          wr_count++;
          cap_adr = o_m_adr;
          cap_dat = o_m_data;
          hi_cnt  = 0;
          acked   = 1'b0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL mwrite_extra: got adr=%h data=%h with nothing expected", o_m_adr,
                     o_m_data);
          end else begin
            e = exp_q.pop_front();
            check("mwrite", {o_m_adr, o_m_data}, e);
          end
          check("mwrite_ctl", {29'd0, o_m_cyc, o_m_we, o_m_stb}, 32'd7);
          if (o_m_adr == 16'd0) prev_dc_cyc = -1;
          if (o_m_adr == 16'd6) begin
            if (prev_dc_cyc >= 0) check("dc_gap", 32'(cyc_n - prev_dc_cyc >= cur_ivl), 32'd1);
            prev_dc_cyc = cyc_n;
          end
          ack_at = (noack_en && o_m_adr == noack_adr) ? -1 : int'($urandom_range(0, 3));
        end else begin
          check("ack_drop", 32'(acked), 32'd0);
          check("mwrite_hold", {o_m_adr, o_m_data}, {cap_adr, cap_dat});
        end
        if (hi_cnt == ack_at) begin
          i_m_ack = 1'b1;
          acked   = 1'b1;
        end else begin
          i_m_ack = 1'b0;
        end
        hi_cnt++;
      end else begin
        if (was_stb && !acked) begin
          tmo_count++;
          check("ack_timeout_len", 32'(hi_cnt), 32'(AckTimeout));
        end
        i_m_ack = 1'b0;
      end
      was_stb = o_m_stb;
    end
  end

  task automatic wb_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge i_wb_clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_adr = a; i_wb_data = d;
    @(negedge i_wb_clk);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [15:0] a, output logic [15:0] d, output logic ack);
    @(negedge i_wb_clk);
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = a;
    #1;
    d   = o_wb_data;
    ack = o_wb_ack;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
  endtask

  task automatic program_cfg(input int dv, input int pr, input int s, input int t,
                             input int st, input int iv);
    wb_write(16'd2, 16'(dv));
    wb_write(16'd4, 16'(pr));
    wb_write(16'd6, 16'(s));
    wb_write(16'd8, 16'(t));
    wb_write(16'd10, 16'(st));
    wb_write(16'd12, 16'(iv));
    cur_ivl = (iv == 0) ? 1 : iv;
  endtask

  task automatic push_init(input int dv, input int pr, input int s);
    exp_q.push_back({16'd0, 16'h0080});
    exp_q.push_back({16'd2, 16'(dv)});
    exp_q.push_back({16'd4, 16'(pr)});
    exp_q.push_back({16'd6, 16'(s)});
    exp_q.push_back({16'd0, 16'h0016});
  endtask

  // Ramp model: move toward target by step, never past it; step 0 jumps straight there
  task automatic push_model_steps(input int s, input int t, input int st);
    int cur, nxt;
    cur = s;
    while (cur != t) begin
      if (st == 0) nxt = t;
      else if (t >= s) nxt = (cur + st > t) ? t : cur + st;
      else nxt = (cur - st < t) ? t : cur - st;
      exp_q.push_back({16'd6, 16'(nxt)});
      cur = nxt;
    end
  endtask

  task automatic wait_irq(input int bound);
    int k;
    k = 0;
    while (!o_irq && k < bound) begin
      @(negedge i_wb_clk);
      k++;
    end
    check("irq_rise", 32'(o_irq), 32'd1);
  endtask

  task automatic finish_ramp(input int t);
    logic [15:0] st;
    logic ack;
    logic [15:0] tv;
    tv = 16'(t);
    wait_irq(3000);
    wb_read(16'd14, st, ack);
    check("status_done", 32'(st), 32'({tv[12:0], 3'b010}));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    wb_write(16'd0, 16'd2);
    check("irq_clear", 32'(o_irq), 32'd0);
    wb_read(16'd14, st, ack);
    check("status_clr", 32'(st[2:0]), 32'd0);
  endtask

  logic [15:0] rd, st, junk;
  logic rack;
  int s, t, stp, dv, pr, iv, dif, base, k;

  initial begin
    // Reset state
    repeat (3) @(negedge i_wb_clk);
    check("rst_mbus", {28'd0, o_m_cyc, o_m_stb, o_m_we, o_irq}, 32'd0);
    check("rst_madr", {o_m_adr, o_m_data}, 32'd0);
    i_wb_rst = 1'b0;
    wb_read(16'd14, rd, rack);
    check("rst_status", 32'(rd), 32'd0);
    check("wb_ack", 32'(rack), 32'd1);
    wb_read(16'd8, rd, rack);
    check("rst_dctgt", 32'(rd), 32'd0);
    wb_read(16'd20, rd, rack);
    check("unmapped_rd", 32'(rd), 32'd0);

    // Up ramp 10 -> 40 in steps of 10
    program_cfg(2, 100, 10, 40, 10, 5);
    wb_read(16'd12, rd, rack);
    check("intvl_rd", 32'(rd), 32'd5);
    push_init(2, 100, 10);
    exp_q.push_back({16'd6, 16'd20});
    exp_q.push_back({16'd6, 16'd30});
    exp_q.push_back({16'd6, 16'd40});
    wb_write(16'd0, 16'd1);
    finish_ramp(40);

    // Down ramp with final clamp
    program_cfg(2, 100, 50, 5, 20, 3);
    push_init(2, 100, 50);
    exp_q.push_back({16'd6, 16'd30});
    exp_q.push_back({16'd6, 16'd10});
    exp_q.push_back({16'd6, 16'd5});
    wb_write(16'd0, 16'd1);
    finish_ramp(5);

    // Step 0: single jump
    program_cfg(3, 200, 0, 1000, 0, 2);
    push_init(3, 200, 0);
    exp_q.push_back({16'd6, 16'd1000});
    wb_write(16'd0, 16'd1);
    finish_ramp(1000);

    // Up ramp near the top of the range must clamp without wrapping
    program_cfg(1, 16'hFFFF, 16'hFFA0, 16'hFFF0, 16'h20, 0);
    push_init(1, 16'hFFFF, 16'hFFA0);
    exp_q.push_back({16'd6, 16'hFFC0});
    exp_q.push_back({16'd6, 16'hFFE0});
    exp_q.push_back({16'd6, 16'hFFF0});
    wb_write(16'd0, 16'd1);
    finish_ramp(16'hFFF0);

    // Randomized ramps against the model; mid-ramp config writes must not matter
    for (int it = 0; it < 10; it++) begin
      dv = int'($urandom_range(0, 65535));
      pr = int'($urandom_range(0, 65535));
      s  = int'($urandom_range(0, 65535));
      t  = (it % 3 == 0) ? s : int'($urandom_range(0, 65535));
      dif = (t > s) ? t - s : s - t;
      stp = ($urandom_range(0, 4) == 0) ? 0 : dif / 10 + int'($urandom_range(1, 300));
      if (stp > 65535) stp = 65535;
      iv = int'($urandom_range(0, 5));
      program_cfg(dv, pr, s, t, stp, iv);
      push_init(dv, pr, s);
      push_model_steps(s, t, stp);
      wb_write(16'd0, 16'd1);
      junk = 16'($urandom);
      wb_write(16'd10, junk);
      wb_write(16'd8, 16'($urandom));
      finish_ramp(t);
      wb_read(16'd10, rd, rack);
      check("cfg_rw", 32'(rd), 32'(junk));
    end

    // Ack timeout while programming the period
    noack_en = 1'b1;
    noack_adr = 16'd4;
    base = tmo_count;
    program_cfg(2, 100, 10, 40, 10, 5);
    exp_q.push_back({16'd0, 16'h0080});
    exp_q.push_back({16'd2, 16'd2});
    exp_q.push_back({16'd4, 16'd100});
    wb_write(16'd0, 16'd1);
    wait_irq(200);
    wb_read(16'd14, st, rack);
    check("tmo_status", 32'(st[2:0]), 32'b100);
    check("tmo_seen", 32'(tmo_count - base), 32'd1);
    check("tmo_queue", 32'(exp_q.size()), 32'd0);
    wb_write(16'd0, 16'd2);
    check("tmo_irq_clr", 32'(o_irq), 32'd0);
    noack_en = 1'b0;

    // Abort during WAIT; a start written mid-ramp is ignored
    program_cfg(2, 100, 10, 40, 10, 200);
    push_init(2, 100, 10);
    exp_q.push_back({16'd0, 16'h0000});
    base = wr_count;
    wb_write(16'd0, 16'd1);
    k = 0;
    while (!(wr_count == base + 5 && !o_m_stb) && k < 200) begin
      @(negedge i_wb_clk);
      k++;
    end
    repeat (5) @(negedge i_wb_clk);
    wb_read(16'd14, st, rack);
    check("abort_busy_before", 32'(st[0]), 32'd1);
    wb_write(16'd0, 16'd1);
    wb_write(16'd0, 16'd4);
    k = 0;
    st = 16'h1;
    while (st[0] && k < 100) begin
      wb_read(16'd14, st, rack);
      k++;
    end
    repeat (30) @(negedge i_wb_clk);
    wb_read(16'd14, st, rack);
    check("abort_status", 32'(st[2:0]), 32'd0);
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    check("abort_irq", 32'(o_irq), 32'd0);

    // Start and abort together while idle: nothing happens
    base = wr_count;
    wb_write(16'd0, 16'd5);
    repeat (20) @(negedge i_wb_clk);
    check("start_abort_idle", 32'(wr_count - base), 32'd0);

    // Reset mid-operation drops the bus at once and clears config
    program_cfg(7, 100, 10, 40, 10, 50);
    push_init(7, 100, 10);
    wb_write(16'd0, 16'd1);
    k = 0;
    while (!o_m_stb && k < 20) begin
      @(negedge i_wb_clk);
      k++;
    end
    check("pre_rst_stb", 32'(o_m_stb), 32'd1);
    #2 i_wb_rst = 1'b1;
    #1;
    check("async_rst_bus", {29'd0, o_m_cyc, o_m_stb, o_irq}, 32'd0);
    repeat (2) @(negedge i_wb_clk);
    i_wb_rst = 1'b0;
    exp_q.delete();
    wb_read(16'd2, rd, rack);
    check("rst_div", 32'(rd), 32'd0);
    wb_read(16'd14, rd, rack);
    check("rst_status2", 32'(rd), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
